// File: rtl/pwm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_pkg : shared PWM widths and move-FSM state encoding           rev 1.0
// ----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_NCH = 8;
  localparam int PWM_CW  = 32;
  localparam int PWM_SW  = 16;
  localparam int PWM_CHW = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } move_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_move_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_move_chan : one channel's move FSM, pulse counter, feedback edge detect
// rev 1.0
// ----------------------------------------------------------------------------
module pwm_move_chan
  import pwm_pkg::*;
#(
  parameter int CW = PWM_CW,
  parameter int SW = PWM_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] steps,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] duty,
  input  logic          dir,
  input  logic          abort,
  input  logic          fb,
  output logic [CW-1:0] period_q,
  output logic [CW-1:0] duty_q,
  output logic          dir_q,
  output logic          en,
  output logic          busy,
  output logic          done
);

  move_state_t   r_state;
  logic [SW-1:0] r_steps;
  logic [SW-1:0] r_cnt;
  logic          r_fb;
  logic          w_fall;
  logic [SW-1:0] w_cnt_next;

  // Falling edge compares the previous registered sample with the live input,
  // so completion lands on the very edge where the last pulse ends.
  assign w_fall     = r_fb & ~fb;
  assign w_cnt_next = r_cnt + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_steps  <= '0;
      r_cnt    <= '0;
      r_fb     <= 1'b0;
      period_q <= '0;
      duty_q   <= '0;
      dir_q    <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            period_q <= period;
            duty_q   <= duty;
            dir_q    <= dir;
            r_steps  <= steps;
            r_cnt    <= '0;
            r_fb     <= 1'b0;
            if (steps != '0) begin
              r_state <= RUN;
              en      <= 1'b1;
              busy    <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          r_fb <= fb;
          if (abort) begin
            r_state <= IDLE;
            en      <= 1'b0;
            busy    <= 1'b0;
          end else if (w_fall) begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == r_steps) begin
              r_state <= IDLE;
              en      <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_move_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_move_ctrl : command decode and output packing for NCH move channels
// rev 1.0
// ----------------------------------------------------------------------------
module pwm_move_ctrl
  import pwm_pkg::*;
#(
  parameter int NCH = PWM_NCH,
  parameter int CW  = PWM_CW,
  parameter int SW  = PWM_SW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PWM_CHW-1:0]  cmd_ch,
  input  logic [SW-1:0]       cmd_steps,
  input  logic [CW-1:0]       cmd_period,
  input  logic [CW-1:0]       cmd_duty,
  input  logic                cmd_dir,
  input  logic [NCH-1:0]      abort,
  input  logic [NCH-1:0]      pwm_fb,
  output logic [NCH*CW-1:0]   period_o,
  output logic [NCH*CW-1:0]   duty_o,
  output logic [NCH-1:0]      en_o,
  output logic [NCH-1:0]      dir_o,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      done
);

  localparam int CH_SLOTS = 1 << PWM_CHW;

  logic [CH_SLOTS-1:0] w_busy_sel;
  logic                w_accept;

  // Addresses with no channel behind them read as busy so they are never taken.
  generate
    if (NCH >= CH_SLOTS) begin : g_busy_full
      assign w_busy_sel = busy[CH_SLOTS-1:0];
    end else begin : g_busy_pad
      assign w_busy_sel = {{(CH_SLOTS-NCH){1'b1}}, busy};
    end
  endgenerate

  assign cmd_ready = ~w_busy_sel[cmd_ch];
  assign w_accept  = cmd_valid & cmd_ready;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic w_start;
      assign w_start = w_accept && (cmd_ch == PWM_CHW'(gi));

      pwm_move_chan #(
        .CW (CW),
        .SW (SW)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .steps    (cmd_steps),
        .period   (cmd_period),
        .duty     (cmd_duty),
        .dir      (cmd_dir),
        .abort    (abort[gi]),
        .fb       (pwm_fb[gi]),
        .period_q (period_o[gi*CW +: CW]),
        .duty_q   (duty_o[gi*CW +: CW]),
        .dir_q    (dir_o[gi]),
        .en       (en_o[gi]),
        .busy     (busy[gi]),
        .done     (done[gi])
      );
    end
  endgenerate

endmodule
`default_nettype wire
